// File: rtl/bp_multi_link_serializer.sv
// bp_multi_link_serializer
//
// Splits wide words from the core wrapper into narrower off-chip link flits,
// least-significant slice first, under credit-based flow control. A word is
// accepted combinationally (multi_yumi_o) when the block is idle, or during
// the cycle the last slice of the current word goes out. Back-to-back words
// therefore stream with no bubble. Each cycle with link_v_o high spends one
// receiver credit. Each cycle with link_token_i high returns one credit.
//
// Parameters
//   noc_width_p    width of a core word; an integer multiple (>= 2x) of link_width_p
//   link_width_p   width of one link flit
//   link_credits_p receiver buffer depth in flits (initial and maximum credit count)
//
// Ports
//   clk_i          clock, all state on the rising edge
//   reset_n_i      asynchronous active-low reset
//   multi_data_i   word from the core
//   multi_v_i      word valid
//   multi_yumi_o   word consumed this cycle
//   link_data_o    outgoing flit (0 when link_v_o is low)
//   link_v_o       flit valid; the flit counts as sent when high
//   link_token_i   one credit returned per high cycle
//   overflow_o     sticky: a token arrived while credits were already full

module bp_multi_link_serializer #(
  parameter int noc_width_p    = 64,
  parameter int link_width_p   = 16,
  parameter int link_credits_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [noc_width_p-1:0]  multi_data_i,
  input  logic                    multi_v_i,
  output logic                    multi_yumi_o,
  output logic [link_width_p-1:0] link_data_o,
  output logic                    link_v_o,
  input  logic                    link_token_i,
  output logic                    overflow_o
);

  localparam int ratio_lp    = noc_width_p / link_width_p;
  localparam int slice_w_lp  = $clog2(ratio_lp);
  localparam int credit_w_lp = $clog2(link_credits_p + 1);

  localparam logic [slice_w_lp-1:0]  last_slice_lp  = slice_w_lp'(ratio_lp - 1);
  localparam logic [credit_w_lp-1:0] max_credits_lp = credit_w_lp'(link_credits_p);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                  state_q, state_d;
  logic [noc_width_p-1:0]  holding_q;
  logic [slice_w_lp-1:0]   slice_q, slice_d;
  logic [credit_w_lp-1:0]  credits_q, credits_d;
  logic                    overflow_q, overflow_set;

  logic send, last, accept;

  // A flit leaves only while serialising and the receiver has room.
  assign send = (state_q == SEND) && (credits_q != '0);
  assign last = (slice_q == last_slice_lp);

  // Acceptance is combinational from state, so it is gated by reset.
  // Otherwise an idle block would acknowledge a word while reset is held.
  assign accept = reset_n_i && multi_v_i && ((state_q == IDLE) || (send && last));

  assign multi_yumi_o = accept;
  assign link_v_o     = send;
  assign link_data_o  = send ? holding_q[slice_q*link_width_p +: link_width_p] : '0;
  assign overflow_o   = overflow_q;

  // NOTE: every combinational output gets a default before the case/if tree.
  // This stops a missed branch from inferring a latch.
  always_comb begin
    state_d = state_q;
    slice_d = slice_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          slice_d = '0;
        end
      end
      SEND: begin
        if (send) begin
          if (last) begin
            // A new word picked up on the last slice keeps the link busy with no gap.
            slice_d = '0;
            state_d = accept ? SEND : IDLE;
          end else begin
            slice_d = slice_q + slice_w_lp'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A token and a send in the same cycle cancel.
  // A token with credits already full cannot be stored; it is flagged as an overflow.
  always_comb begin
    credits_d    = credits_q;
    overflow_set = 1'b0;
    if (link_token_i && !send) begin
      if (credits_q == max_credits_lp) overflow_set = 1'b1;
      else                             credits_d    = credits_q + credit_w_lp'(1);
    end else if (send && !link_token_i) begin
      credits_d = credits_q - credit_w_lp'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      slice_q    <= '0;
      credits_q  <= max_credits_lp;
      overflow_q <= 1'b0;
      // NOTE: the holding register is a plain register, not a RAM. It is
      // cleared on reset so that a partial word never survives reset.
      holding_q  <= '0;
    end else begin
      state_q   <= state_d;
      slice_q   <= slice_d;
      credits_q <= credits_d;
      if (overflow_set) overflow_q <= 1'b1;
      if (accept)       holding_q  <= multi_data_i;
    end
  end

endmodule

// File: tb/tb_bp_multi_link_serializer.sv
// Self-checking bench for bp_multi_link_serializer (default parameters).
// Expected flits are pushed to a scoreboard queue when a word is driven.
// A negedge monitor pops and compares each flit the DUT emits.
// A table of words is streamed back-to-back.
// Hand-written sequences cover the following:
//   - credit exhaustion
//   - a token arriving together with a send
//   - overflow
//   - reset in the middle of a word

module tb_bp_multi_link_serializer;

  logic        clk_i;
  logic        reset_n_i;
  logic [63:0] multi_data_i;
  logic        multi_v_i;
  logic        multi_yumi_o;
  logic [15:0] link_data_o;
  logic        link_v_o;
  logic        link_token_i;
  logic        overflow_o;

  bp_multi_link_serializer #(
    .noc_width_p   (64),
    .link_width_p  (16),
    .link_credits_p(8)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .multi_data_i(multi_data_i),
    .multi_v_i   (multi_v_i),
    .multi_yumi_o(multi_yumi_o),
    .link_data_o (link_data_o),
    .link_v_o    (link_v_o),
    .link_token_i(link_token_i),
    .overflow_o  (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int flit_count = 0;
  int acc_cyc = 0;

  logic [15:0] sb[$];

  // A token source: either driven directly, or echoed one cycle after each
  // flit, as a receiver that drains immediately would do.
  logic manual_token;
  logic auto_en;
  logic prev_v = 1'b0;
  always @(posedge clk_i) prev_v <= link_v_o;
  assign link_token_i = manual_token | (auto_en & prev_v);

  typedef struct {
    logic [63:0] word;
    logic [15:0] f0, f1, f2, f3;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_yumi"},     64'(multi_yumi_o), 64'd0);
    check({tag, "_link_v"},   64'(link_v_o),     64'd0);
    check({tag, "_link_data"},64'(link_data_o),  64'd0);
    check({tag, "_overflow"}, 64'(overflow_o),   64'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [15:0] slice_of(input logic [63:0] w, input int k);
    return w[16*k +: 16];
  endfunction

  // Present a word and wait (bounded) for it to be consumed.
  // Pushes the first npush slices of the word to the scoreboard.
  // Returns just after the accepting edge, with multi_v_i still high.
  task automatic feed(input logic [63:0] w, input int npush);
    bit got;
    got = 1'b0;
    for (int k = 0; k < npush; k++) sb.push_back(slice_of(w, k));
    multi_data_i = w;
    multi_v_i    = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk_i);
      if (multi_yumi_o) begin
        got     = 1'b1;
        acc_cyc = cyc;
      end else begin
        next_cycle();
      end
    end
    check("word_accepted", 64'(got), 64'd1);
    next_cycle();
  endtask

  // Cycle counter, read only at the negedge.
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Flit monitor and scoreboard.
  initial forever begin
    logic [15:0] exp;
    @(negedge clk_i);
    if (reset_n_i) begin
      if (link_v_o) begin
        flit_count++;
        check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("flit_data", 64'(link_data_o), 64'(exp));
        end
      end else begin
        check("idle_data_zero", 64'(link_data_o), 64'd0);
      end
      if (!multi_v_i) check("yumi_without_v", 64'(multi_yumi_o), 64'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    int start;
    int acc[5];

    tbl[0] = '{64'h0000000000000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[2] = '{64'h0123456789ABCDEF, 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    tbl[3] = '{64'hA5A55A5AFFFF0001, 16'h0001, 16'hFFFF, 16'h5A5A, 16'hA5A5};
    tbl[4] = '{64'hDEADBEEFCAFEF00D, 16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD};

    // Reset: outputs stay quiet even with a valid word offered and a clock edge seen.
    reset_n_i    = 1'b0;
    multi_v_i    = 1'b1;
    multi_data_i = 64'h1122334455667788;
    manual_token = 1'b0;
    auto_en      = 1'b0;
    #12;
    check_idle_outputs("rst_a");
    #10;
    check_idle_outputs("rst_b");
    multi_v_i = 1'b0;
    #1;
    reset_n_i = 1'b1;
    next_cycle();

    // Single word: accepted the cycle it is offered, four flits next, then idle.
    auto_en = 1'b1;
    fc    = flit_count;
    start = cyc;
    feed(64'h1122334455667788, 4);
    multi_v_i = 1'b0;
    check("a_accept_cycle", 64'(acc_cyc), 64'(start));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      check("a_link_v", 64'(link_v_o), 64'd1);
      check("a_yumi_low", 64'(multi_yumi_o), 64'd0);
      next_cycle();
    end
    @(negedge clk_i);
    check("a_link_v_end", 64'(link_v_o), 64'd0);
    repeat (3) next_cycle();
    check("a_flits", 64'(flit_count - fc), 64'd4);

    // Table of words streamed back-to-back with credits flowing.
    fc = flit_count;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(tbl[i].f0);
      sb.push_back(tbl[i].f1);
      sb.push_back(tbl[i].f2);
      sb.push_back(tbl[i].f3);
      feed(tbl[i].word, 0);
      acc[i] = acc_cyc;
      if (i > 0) check("b_accept_spacing", 64'(acc[i] - acc[i-1]), 64'd4);
    end
    multi_v_i = 1'b0;
    repeat (8) next_cycle();
    check("b_flits", 64'(flit_count - fc), 64'd20);

    // Credit exhaustion: three words and no tokens.
    auto_en = 1'b0;
    repeat (2) next_cycle();
    fc = flit_count;
    feed(64'hCAFEBABE01234567, 4);
    feed(64'h0F0F0F0FF0F0F0F0, 4);
    feed(64'h1122334455667788, 0);
    multi_v_i = 1'b0;
    repeat (6) next_cycle();
    @(negedge clk_i);
    check("c_stalled", 64'(link_v_o), 64'd0);
    check("c_flits_8", 64'(flit_count - fc), 64'd8);
    next_cycle();
    // One token pulse releases exactly one flit (slice 0 of the held word).
    sb.push_back(16'h7788);
    manual_token = 1'b1;
    next_cycle();
    manual_token = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk_i);
    check("c_one_flit_v", 64'(link_v_o), 64'd0);
    check("c_flits_9", 64'(flit_count - fc), 64'd9);
    next_cycle();

    // A token in the same cycle as a send, with credits at 1, keeps the link going.
    sb.push_back(16'h5566);
    sb.push_back(16'h3344);
    sb.push_back(16'h1122);
    manual_token = 1'b1;
    @(negedge clk_i);
    check("c_sim_before", 64'(link_v_o), 64'd0);
    next_cycle();
    @(negedge clk_i);
    check("c_sim_v1", 64'(link_v_o), 64'd1);
    next_cycle();
    @(negedge clk_i);
    check("c_sim_v2", 64'(link_v_o), 64'd1);
    next_cycle();
    manual_token = 1'b0;
    @(negedge clk_i);
    check("c_sim_v3", 64'(link_v_o), 64'd1);
    next_cycle();
    @(negedge clk_i);
    check("c_sim_end", 64'(link_v_o), 64'd0);
    next_cycle();
    check("c_flits_12", 64'(flit_count - fc), 64'd12);

    // Overflow: refill to exactly full without error, then one token too many.
    manual_token = 1'b1;
    repeat (8) next_cycle();
    manual_token = 1'b0;
    @(negedge clk_i);
    check("d_full_no_ovf", 64'(overflow_o), 64'd0);
    next_cycle();
    manual_token = 1'b1;
    next_cycle();
    manual_token = 1'b0;
    @(negedge clk_i);
    check("d_ovf_set", 64'(overflow_o), 64'd1);
    repeat (3) next_cycle();
    @(negedge clk_i);
    check("d_ovf_sticky", 64'(overflow_o), 64'd1);
    next_cycle();
    // Credits stayed saturated at 8: exactly 8 flits go out, then a stall.
    fc = flit_count;
    feed(64'h0011223344556677, 4);
    feed(64'h8899AABBCCDDEEFF, 4);
    multi_v_i = 1'b0;
    repeat (6) next_cycle();
    check("d_flits_8", 64'(flit_count - fc), 64'd8);
    feed(64'h13579BDF2468ACE0, 0);
    multi_v_i = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk_i);
    check("d_no_ninth", 64'(link_v_o), 64'd0);
    check("d_flits_still_8", 64'(flit_count - fc), 64'd8);
    next_cycle();

    // Two tokens send 2 of 4 flits, then reset lands mid-word.
    sb.push_back(16'hACE0);
    sb.push_back(16'h2468);
    manual_token = 1'b1;
    next_cycle();
    next_cycle();
    manual_token = 1'b0;
    next_cycle();
    @(negedge clk_i);
    check("e_two_sent_v", 64'(link_v_o), 64'd0);
    check("e_flits_10", 64'(flit_count - fc), 64'd10);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_idle_outputs("e_rst");
    @(posedge clk_i);
    #3;
    reset_n_i = 1'b1;
    repeat (4) next_cycle();
    @(negedge clk_i);
    check("e_no_leftover_v", 64'(link_v_o), 64'd0);
    check("e_no_leftover", 64'(flit_count - fc), 64'd10);
    next_cycle();
    // Fresh words start at slice 0, and a full 8 credits are available without tokens.
    fc = flit_count;
    feed(64'h7766554433221100, 4);
    feed(64'hF0E1D2C3B4A59687, 4);
    multi_v_i = 1'b0;
    repeat (6) next_cycle();
    check("e_flits_8", 64'(flit_count - fc), 64'd8);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_multi_link_serializer.md
BP_MULTI_LINK_SERIALIZER -- requirements
Module: bp_multi_link_serializer

Interface
REQ-001 SHALL have parameter noc_width_p, default 64: width of a multi-channel word from the core wrapper.
REQ-002 SHALL have parameter link_width_p, default 16: width of one off-chip link flit; noc_width_p SHALL be an integer multiple of link_width_p, with ratio (noc_width_p/link_width_p) >= 2.
REQ-003 SHALL have parameter link_credits_p, default 8: receiver buffer depth in link flits.
REQ-004 SHALL have port clk_i, input, 1 bit: the only clock; all state on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port multi_data_i, input, noc_width_p bits: word from the core's multi_data_o.
REQ-007 SHALL have port multi_v_i, input, 1 bit: word valid.
REQ-008 SHALL have port multi_yumi_o, output, 1 bit: word consumed this cycle.
REQ-009 SHALL have port link_data_o, output, link_width_p bits: outgoing flit.
REQ-010 SHALL have port link_v_o, output, 1 bit: flit valid, counted as sent when high.
REQ-011 SHALL have port link_token_i, input, 1 bit: one credit returned per high cycle.
REQ-012 SHALL have port overflow_o, output, 1 bit: sticky credit-overflow error.

Function
REQ-013 SHALL implement FSM states IDLE and SEND, a holding register (noc_width_p), a slice counter (0..ratio-1) and a credit counter (0..link_credits_p).
REQ-014 In IDLE with multi_v_i=1, SHALL assert multi_yumi_o combinationally, capture multi_data_i, clear the slice counter and enter SEND.
REQ-015 multi_yumi_o SHALL never be high while multi_v_i is low.
REQ-016 In SEND, link_v_o SHALL be high iff credits > 0.
REQ-017 When link_v_o is high, link_data_o SHALL equal holding[slice*link_width_p +: link_width_p], LSB slice first; otherwise link_data_o SHALL be 0.
REQ-018 Each cycle with link_v_o high SHALL increment the slice counter and decrement credits.
REQ-019 When the last slice (ratio-1) is sent and multi_v_i=1, the block SHALL assert multi_yumi_o that same cycle, capture the new word, reset the slice counter to 0 and remain in SEND, leaving no bubble.
REQ-020 When the last slice is sent and multi_v_i=0, the block SHALL return to IDLE.
REQ-021 In SEND with credits=0, all state except credits SHALL hold, and link_v_o SHALL be 0.
REQ-022 A token with no send SHALL give credits+1; a send with no token SHALL give credits-1; a token and a send in the same cycle SHALL leave credits unchanged.
REQ-023 A token arriving while credits = link_credits_p with no send in that cycle SHALL leave credits saturated and set overflow_o, which SHALL stay high until reset.
REQ-024 Latency: a word accepted in cycle N SHALL put its first flit on the link in cycle N+1, given credits are available.
REQ-025 Throughput: with credits available, one word SHALL be sent every ratio cycles.

Reset
REQ-026 While reset_n_i=0, regardless of clk_i, the block SHALL be in IDLE with slice=0, credits=link_credits_p, holding register=0, multi_yumi_o=0, link_v_o=0, link_data_o=0 and overflow_o=0.
REQ-027 Reset asserted mid-word SHALL discard the partial word; no further flits of that word SHALL be sent after reset is released.
REQ-028 After reset_n_i rises, the first acceptance SHALL occur no earlier than the first rising clock edge following the deassertion.

Verification
REQ-029 Single word (defaults): multi_data_i=0x1122334455667788 held valid in cycle N, credits full -> multi_yumi_o=1 in cycle N only; link_data_o=0x7788, 0x5566, 0x3344, 0x1122 in cycles N+1 to N+4; link_v_o=0 in cycle N+5.
REQ-030 Back-to-back: two words held valid -> 8 consecutive valid flits with no gap; the second yumi occurs in cycle N+4.
REQ-031 Credit exhaustion: three words, no tokens -> exactly 8 flits, then link_v_o=0 with the third word held at slice 0; one token pulse -> exactly one flit 0x7788 of the third word.
REQ-032 Simultaneous events: credits=1 with a token in the same cycle as a send -> credits remain 1 and the next slice is sent in the following cycle.
REQ-033 Overflow: with credits=8 and the block idle, one token pulse -> overflow_o=1 and remaining high; credits stay 8.
REQ-034 Reset mid-word: reset_n_i pulsed low after 2 of 4 flits -> all outputs 0 immediately; after release, the next accepted word starts at slice 0 with credits=8.
